// File: rtl/ex_muldiv.sv
// RV32M execute unit: iterative shift-add multiplier and restoring divider, one bit per cycle.
// Holds the ID/EX stage via stallReq_out until the result is presented for one cycle.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            pcJump_in,
    input  logic            start_in,
    input  logic [2:0]      op_in,
    input  logic [XLEN-1:0] rs1Data_in,
    input  logic [XLEN-1:0] rs2Data_in,
    input  logic [4:0]      rdIdx_in,
    output logic            stallReq_out,
    output logic            rdE_out,
    output logic [4:0]      rdIdx_out,
    output logic [XLEN-1:0] rdData_out
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0]   ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE2     = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_LAST = {CW{1'b1}};

    function automatic logic [XLEN-1:0] f_cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    state_t             r_state;
    state_t             w_next_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [4:0]         r_rd_idx;
    logic [XLEN-1:0]    r_opa;
    logic [2*XLEN-1:0]  r_acc;
    logic               r_neg;
    logic               r_rde;
    logic [4:0]         r_rd_idx_out;
    logic [XLEN-1:0]    r_rd_data;

    logic               w_accept;
    logic               w_stall;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_a_mag;
    logic [XLEN-1:0]    w_b_mag;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_fast;
    logic [XLEN-1:0]    w_fast_data;
    logic               w_neg_init;
    logic [XLEN:0]      w_mul_sum;
    logic [2*XLEN-1:0]  w_mul_next;
    logic [XLEN:0]      w_rem_sh;
    logic               w_ge;
    logic [XLEN-1:0]    w_rem_sub;
    logic [2*XLEN-1:0]  w_div_next;
    logic [2*XLEN-1:0]  w_step;
    logic [2*XLEN-1:0]  w_raw;
    logic [2*XLEN-1:0]  w_fix;
    logic [XLEN-1:0]    w_result;
    logic               w_last;

    // Operand decode at accept: signedness, magnitudes and the single-cycle corner cases.
    always_comb begin
        w_accept   = (r_state == ST_IDLE) && start_in && !pcJump_in;
        w_a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
        w_b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        w_a_neg    = w_a_signed && rs1Data_in[XLEN-1];
        w_b_neg    = w_b_signed && rs2Data_in[XLEN-1];
        w_a_mag    = f_cond_neg(rs1Data_in, w_a_neg);
        w_b_mag    = f_cond_neg(rs2Data_in, w_b_neg);
        w_div_zero = op_in[2] && (rs2Data_in == ZERO);
        w_ovf      = op_in[2] && !op_in[0] && (rs1Data_in == SMIN) && (rs2Data_in == ONES);
        w_fast     = w_div_zero || w_ovf;
        // Remainder sign follows the dividend; everything else takes the product/quotient sign.
        w_neg_init = (op_in[2] && op_in[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        if (w_div_zero) begin
            w_fast_data = op_in[1] ? rs1Data_in : ONES;
        end else begin
            w_fast_data = op_in[1] ? ZERO : SMIN;
        end
    end

    // One iteration of either engine plus final sign correction and result selection.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opa : ZERO)};
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
        w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_opa});
        w_rem_sub  = w_rem_sh[XLEN-1:0] - r_opa;
        w_div_next = {(w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
        w_step     = r_op[2] ? w_div_next : w_mul_next;
        if (r_op[2]) begin
            w_raw = r_op[1] ? {ZERO, w_step[2*XLEN-1:XLEN]} : {ZERO, w_step[XLEN-1:0]};
        end else begin
            w_raw = w_step;
        end
        w_fix = r_neg ? (~w_raw + ONE2) : w_raw;
        case (r_op)
            OP_MUL:                       w_result = w_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_result = w_fix[2*XLEN-1:XLEN];
            default:                      w_result = w_fix[XLEN-1:0];
        endcase
        w_last = (r_cnt == CNT_LAST);
    end

    // Next-state and stall request.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_fast ? ST_DONE : ST_BUSY;
                    w_stall      = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (pcJump_in) begin
                    w_next_state = ST_IDLE;
                end else if (w_last) begin
                    w_next_state = ST_DONE;
                    w_stall      = 1'b1;
                end else begin
                    w_next_state = ST_BUSY;
                    w_stall      = 1'b1;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand latch, iteration and registered result.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt        <= {CW{1'b0}};
            r_op         <= 3'd0;
            r_rd_idx     <= 5'd0;
            r_opa        <= ZERO;
            r_acc        <= {ZERO, ZERO};
            r_neg        <= 1'b0;
            r_rde        <= 1'b0;
            r_rd_idx_out <= 5'd0;
            r_rd_data    <= ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op     <= op_in;
                        r_rd_idx <= rdIdx_in;
                        r_neg    <= w_neg_init;
                        r_cnt    <= {CW{1'b0}};
                        // Divider iterates over the dividend; multiplier over operand B.
                        if (op_in[2]) begin
                            r_opa <= w_b_mag;
                            r_acc <= {ZERO, w_a_mag};
                        end else begin
                            r_opa <= w_a_mag;
                            r_acc <= {ZERO, w_b_mag};
                        end
                        if (w_fast) begin
                            r_rde        <= 1'b1;
                            r_rd_idx_out <= rdIdx_in;
                            r_rd_data    <= w_fast_data;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!pcJump_in) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + CNT_ONE;
                        if (w_last) begin
                            r_rde        <= 1'b1;
                            r_rd_idx_out <= r_rd_idx;
                            r_rd_data    <= w_result;
                        end
                    end
                end
                ST_DONE: r_rde <= 1'b0;
                default: r_rde <= 1'b0;
            endcase
        end
    end

    // A flush arriving while the result is presented cancels the register write.
    assign rdE_out      = r_rde && !pcJump_in;
    assign rdIdx_out    = r_rd_idx_out;
    assign rdData_out   = r_rd_data;
    assign stallReq_out = rst_in && w_stall;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases, flush, async reset and random ops
// against a plain-arithmetic reference model.
module tb_ex_muldiv;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        pcJump_in;
    logic        start_in;
    logic [2:0]  op_in;
    logic [31:0] rs1Data_in;
    logic [31:0] rs2Data_in;
    logic [4:0]  rdIdx_in;
    logic        stallReq_out;
    logic        rdE_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_data;
    logic [4:0]  last_idx;

    always #5 clk_in = ~clk_in;

    ex_muldiv #(.XLEN(32)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .pcJump_in    (pcJump_in),
        .start_in     (start_in),
        .op_in        (op_in),
        .rs1Data_in   (rs1Data_in),
        .rs2Data_in   (rs2Data_in),
        .rdIdx_in     (rdIdx_in),
        .stallReq_out (stallReq_out),
        .rdE_out      (rdE_out),
        .rdIdx_out    (rdIdx_out),
        .rdData_out   (rdData_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result straight from the RV32M definitions using 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      sp;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin sp = sa * sb; p = sp; return p[63:32]; end
            3'd2: begin sp = sa * ub; p = sp; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                sp = sa / sb; p = sp; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
            3'd6: begin
                if (b == 32'd0) return a;
                sp = sa % sb; p = sp; return p[31:0];
            end
            default: return (b == 32'd0) ? a : (a % b);
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp;
        logic        fast;
        int          lat;
        int          n;
        int          stall_cyc;
        exp  = ref_res(op, a, b);
        fast = op[2] && ((b == 32'd0) || (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
        lat  = fast ? 1 : 33;
        @(negedge clk_in);
        start_in   = 1'b1;
        pcJump_in  = 1'b0;
        op_in      = op;
        rs1Data_in = a;
        rs2Data_in = b;
        rdIdx_in   = rd;
        #1;
        chk("idle_rde", 32'(rdE_out), 32'd0);
        chk("hold_data", rdData_out, last_data);
        chk("hold_idx", 32'(rdIdx_out), 32'(last_idx));
        n = 0;
        stall_cyc = 0;
        while (rdE_out !== 1'b1 && n < 40) begin
            if (stallReq_out === 1'b1) stall_cyc++;
            @(negedge clk_in);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("stall_cycles", 32'(stall_cyc), 32'(lat));
        chk("done_stall", 32'(stallReq_out), 32'd0);
        chk("rd_idx", 32'(rdIdx_out), 32'(rd));
        chk("rd_data", rdData_out, exp);
        start_in  = 1'b0;
        last_data = exp;
        last_idx  = rd;
    endtask

    initial begin
        int pulses;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_in     = 1'b0;
        pcJump_in  = 1'b0;
        start_in   = 1'b1;
        op_in      = 3'd0;
        rs1Data_in = 32'd1;
        rs2Data_in = 32'd1;
        rdIdx_in   = 5'd1;
        last_data  = 32'd0;
        last_idx   = 5'd0;
        #1;
        chk("rst_rde", 32'(rdE_out), 32'd0);
        chk("rst_data", rdData_out, 32'd0);
        chk("rst_idx", 32'(rdIdx_out), 32'd0);
        chk("rst_stall", 32'(stallReq_out), 32'd0);
        repeat (2) @(negedge clk_in);
        start_in = 1'b0;
        rst_in   = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10);
        run_op(3'd5, 32'd100, 32'd7, 5'd11);
        run_op(3'd7, 32'd100, 32'd7, 5'd12);
        run_op(3'd4, 32'h0000_1234, 32'd0, 5'd13);
        run_op(3'd6, 32'h0000_1234, 32'd0, 5'd14);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);

        // Flush a DIVU while the iteration counter reads 10.
        @(negedge clk_in);
        start_in   = 1'b1;
        op_in      = 3'd5;
        rs1Data_in = 32'd1000;
        rs2Data_in = 32'd3;
        rdIdx_in   = 5'd20;
        repeat (11) @(negedge clk_in);
        pcJump_in = 1'b1;
        start_in  = 1'b0;
        #1;
        chk("flush_stall", 32'(stallReq_out), 32'd0);
        @(negedge clk_in);
        pcJump_in = 1'b0;
        #1;
        chk("flush_idle_stall", 32'(stallReq_out), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk_in);
            #1;
            if (rdE_out === 1'b1) pulses++;
        end
        chk("flush_no_rde", 32'(pulses), 32'd0);
        chk("flush_hold", rdData_out, last_data);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk_in);
        start_in   = 1'b1;
        op_in      = 3'd0;
        rs1Data_in = 32'h0000_1234;
        rs2Data_in = 32'd5;
        rdIdx_in   = 5'd17;
        repeat (5) @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        chk("midrst_rde", 32'(rdE_out), 32'd0);
        chk("midrst_data", rdData_out, 32'd0);
        chk("midrst_idx", 32'(rdIdx_out), 32'd0);
        chk("midrst_stall", 32'(stallReq_out), 32'd0);
        @(negedge clk_in);
        start_in = 1'b0;
        @(negedge clk_in);
        rst_in    = 1'b1;
        last_data = 32'd0;
        last_idx  = 5'd0;
        run_op(3'd0, 32'd3, 32'd4, 5'd2);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            run_op(rop, ra, rb, 5'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle RV32M execute unit on the consumer side of the ID/EX pipeline register.
- Takes the decoded operand bundle held in ID/EX and requests a stall so ID/EX holds the instruction until the result is ready.
- Returns the result for the EX/MEM path: one 32-bit iterative shift-add multiplier and one restoring divider, one bit per cycle.
- Flush (pcJump_in) aborts an in-flight operation.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- pcJump_in  input  1  flush from branch/jump resolution; 1 = Jump.
- start_in  input  1  ID/EX holds an M-extension instruction.
- op_in  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1Data_in  input  XLEN  operand A from ID/EX.
- rs2Data_in  input  XLEN  operand B from ID/EX.
- rdIdx_in  input  5  destination register from ID/EX.
- stallReq_out  output  1  stall request to the stall controller (holds IF/ID/ID-EX).
- rdE_out  output  1  result-valid / register write enable, one-cycle pulse.
- rdIdx_out  output  5  destination register for the result.
- rdData_out  output  XLEN  result.

Behaviour:
- Reset (rst_in=0, asynchronous): state IDLE, counter 0.
  - rdE_out=0, rdIdx_out=0, rdData_out=0.
  - stallReq_out=0 while reset is held.
- States:
  - IDLE: waiting.
  - BUSY: iterating, 5-bit counter.
  - DONE: presenting the result.
- stallReq_out is combinational:
  - 1 in IDLE when start_in=1 and pcJump_in=0.
  - 1 in BUSY when pcJump_in=0.
  - 0 otherwise, including DONE.
- IDLE:
  - Accepts when start_in=1 and pcJump_in=0.
  - On accept, latches op, rdIdx, operand magnitudes (taken as signed for MULH/DIV/REM, A only for MULHSU) and result-sign flags.
  - Normal case goes to BUSY with counter=0.
  - Fast path, straight to DONE (latency 1):
    - divide by zero (B=0): DIV/DIVU result 0xFFFFFFFF; REM/REMU result A.
    - signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- BUSY:
  - Multiplier: one shift-add step per cycle on a 2*XLEN accumulator.
  - Divider: one restoring subtract/shift step per cycle.
  - After the step with counter=XLEN-1, applies sign correction (two's-complement negate when the sign flag is set) and goes to DONE.
  - 32 BUSY cycles in total.
- Result selection:
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word of the 64-bit signed-corrected product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder; its sign follows the dividend.
- DONE:
  - rdE_out=1, rdIdx_out and rdData_out valid for exactly one cycle; stallReq_out=0, so ID/EX advances on this edge.
  - Next edge: IDLE, rdE_out=0; rdData_out/rdIdx_out hold their last values.
- Latency: normal op has stall high for 33 cycles (accept cycle + 32 BUSY); result visible in cycle 33 after accept.
- Flush:
  - pcJump_in=1 in BUSY or DONE → IDLE at the next edge; rdE_out=0 and no result is written.
  - pcJump_in=1 in IDLE blocks acceptance.
- Back-to-back: a new start_in in the cycle after DONE is accepted normally.
- Reset asserted mid-operation: immediate return to reset values; the operation is discarded.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), rdIdx 5 → stallReq_out high 33 cycles; then rdE_out=1 for one cycle, rdIdx_out=5, rdData_out=0xFFFFFFEB.
- High products:
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9(-7)/2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2.
- Fast path (stallReq_out high for the accept cycle only, DONE the next cycle):
  - DIV 0x1234/0 → 0xFFFFFFFF; REM 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Start DIVU, assert pcJump_in for one cycle at BUSY counter=10 → IDLE next edge, stallReq_out=0, no rdE_out pulse afterwards.
- Drive rst_in=0 between clock edges during BUSY → rdE_out/rdData_out/rdIdx_out/stallReq_out go to 0 without a clock edge. After release, a fresh MUL 3×4 → 12.
